// File: rtl/vga_pkg.sv
// Shared VGA/VRAM definitions: 640x480@60 timing constants, default VRAM
// geometry and the frame-clear FSM state encoding.
package vga_pkg;

  localparam int H_VISIBLE = 640;
  localparam int H_FRONT   = 16;
  localparam int H_SYNC    = 96;
  localparam int H_BACK    = 48;
  localparam int V_VISIBLE = 480;
  localparam int V_FRONT   = 10;
  localparam int V_SYNC    = 2;
  localparam int V_BACK    = 33;

  localparam int VRAM_ADDR_WIDTH = 16;
  localparam int VRAM_DATA_WIDTH = 16;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } clr_state_t;

endpackage

// File: rtl/vram_clear_engine.sv
// Frame-clear engine: walks a pointer from 0 to CLEAR_LAST writing a constant,
// advancing only on slots the arbiter grants; a new start restarts at 0.
module vram_clear_engine
  import vga_pkg::*;
#(
  parameter int ADDR_WIDTH = VRAM_ADDR_WIDTH,
  parameter int DATA_WIDTH = VRAM_DATA_WIDTH,
  parameter int CLEAR_LAST = 19199
) (
  input  logic                  clk_25m,
  input  logic                  rst_n,
  input  logic                  i_start,
  input  logic [DATA_WIDTH-1:0] i_value,
  input  logic                  i_blank,
  input  logic                  i_grant,
  output logic                  o_want,
  output logic                  o_busy,
  output logic [ADDR_WIDTH-1:0] o_addr,
  output logic [DATA_WIDTH-1:0] o_wdata
);

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(CLEAR_LAST);

  clr_state_t            r_state;
  clr_state_t            w_state_nxt;
  logic [ADDR_WIDTH-1:0] r_ptr;
  logic [ADDR_WIDTH-1:0] w_ptr_nxt;
  logic [DATA_WIDTH-1:0] r_value;
  logic                  w_last;

  assign w_last = (r_ptr == LAST_ADDR);

  always_ff @(posedge clk_25m or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_ptr   <= '0;
      r_value <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_ptr   <= w_ptr_nxt;
      if (i_start) r_value <= i_value;
    end
  end

  // A start pulse always wins over a write granted in the same cycle.
  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    if (r_state == ST_IDLE) begin
      if (i_start) begin
        w_state_nxt = ST_CLEAR;
        w_ptr_nxt   = '0;
      end
    end else begin
      if (i_start) begin
        w_ptr_nxt = '0;
      end else if (i_grant) begin
        if (w_last) begin
          w_state_nxt = ST_IDLE;
          w_ptr_nxt   = '0;
        end else begin
          w_ptr_nxt = r_ptr + ADDR_WIDTH'(1);
        end
      end
    end
  end

  assign o_busy  = (r_state == ST_CLEAR);
  assign o_want  = o_busy & i_blank;
  assign o_addr  = r_ptr;
  assign o_wdata = r_value;

endmodule

// File: rtl/vram_arbiter.sv
// Single-port VRAM arbiter: pixel fetch > blanking-time clear > CPU, with a
// registered command stage and a fixed 2-cycle tagged read-return pipeline.
module vram_arbiter
  import vga_pkg::*;
#(
  parameter int ADDR_WIDTH   = VRAM_ADDR_WIDTH,
  parameter int DATA_WIDTH   = VRAM_DATA_WIDTH,
  parameter int CLEAR_LAST   = 19199,
  parameter int STARVE_LIMIT = 64
) (
  input  logic                  clk_25m,
  input  logic                  rst_n,
  input  logic                  in_blank,
  input  logic                  pix_req,
  input  logic [ADDR_WIDTH-1:0] pix_addr,
  output logic                  pix_rvalid,
  output logic [DATA_WIDTH-1:0] pix_rdata,
  input  logic                  cpu_valid,
  input  logic                  cpu_we,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  input  logic [DATA_WIDTH-1:0] cpu_wdata,
  output logic                  cpu_ready,
  output logic                  cpu_rvalid,
  output logic [DATA_WIDTH-1:0] cpu_rdata,
  input  logic                  clear_start,
  input  logic [DATA_WIDTH-1:0] clear_value,
  output logic                  clear_busy,
  output logic                  cpu_starved,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  localparam int                CNT_W     = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0]  LIMIT_CNT = CNT_W'(STARVE_LIMIT);

  logic                  w_clr_want;
  logic                  w_clr_busy;
  logic [ADDR_WIDTH-1:0] w_clr_addr;
  logic [DATA_WIDTH-1:0] w_clr_wdata;
  logic                  w_clr_gnt;
  logic                  w_cpu_gnt;

  logic                  r_mem_en;
  logic                  r_mem_we;
  logic [ADDR_WIDTH-1:0] r_mem_addr;
  logic [DATA_WIDTH-1:0] r_mem_wdata;
  logic                  r_pix_tag_p0;
  logic                  r_cpu_tag_p0;
  logic                  r_pix_tag_p1;
  logic                  r_cpu_tag_p1;
  logic                  r_pix_rvalid;
  logic                  r_cpu_rvalid;
  logic [DATA_WIDTH-1:0] r_pix_rdata;
  logic [DATA_WIDTH-1:0] r_cpu_rdata;
  logic [CNT_W-1:0]      r_wait;
  logic [CNT_W-1:0]      w_wait_nxt;
  logic                  r_starved;

  vram_clear_engine #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH),
    .CLEAR_LAST (CLEAR_LAST)
  ) u_clear (
    .clk_25m (clk_25m),
    .rst_n   (rst_n),
    .i_start (clear_start),
    .i_value (clear_value),
    .i_blank (in_blank),
    .i_grant (w_clr_gnt),
    .o_want  (w_clr_want),
    .o_busy  (w_clr_busy),
    .o_addr  (w_clr_addr),
    .o_wdata (w_clr_wdata)
  );

  // Fixed priority; the CPU is held off only while the clear is actually eligible.
  assign w_clr_gnt = w_clr_want & ~pix_req;
  assign w_cpu_gnt = cpu_valid & ~pix_req & ~w_clr_want;
  assign cpu_ready = w_cpu_gnt;

  always_ff @(posedge clk_25m or negedge rst_n) begin
    if (!rst_n) begin
      r_mem_en     <= 1'b0;
      r_mem_we     <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_wdata  <= '0;
      r_pix_tag_p0 <= 1'b0;
      r_cpu_tag_p0 <= 1'b0;
    end else begin
      r_mem_en     <= pix_req | w_clr_gnt | w_cpu_gnt;
      r_mem_we     <= w_clr_gnt | (w_cpu_gnt & cpu_we);
      r_pix_tag_p0 <= pix_req;
      r_cpu_tag_p0 <= w_cpu_gnt & ~cpu_we;
      if (pix_req) begin
        r_mem_addr <= pix_addr;
      end else if (w_clr_gnt) begin
        r_mem_addr  <= w_clr_addr;
        r_mem_wdata <= w_clr_wdata;
      end else if (w_cpu_gnt) begin
        r_mem_addr <= cpu_addr;
        if (cpu_we) r_mem_wdata <= cpu_wdata;
      end
    end
  end

  // Tags ride alongside the RAM's own latency; async reset drops in-flight returns.
  always_ff @(posedge clk_25m or negedge rst_n) begin
    if (!rst_n) begin
      r_pix_tag_p1 <= 1'b0;
      r_cpu_tag_p1 <= 1'b0;
      r_pix_rvalid <= 1'b0;
      r_cpu_rvalid <= 1'b0;
      r_pix_rdata  <= '0;
      r_cpu_rdata  <= '0;
    end else begin
      r_pix_tag_p1 <= r_pix_tag_p0;
      r_cpu_tag_p1 <= r_cpu_tag_p0;
      r_pix_rvalid <= r_pix_tag_p1;
      r_cpu_rvalid <= r_cpu_tag_p1;
      if (r_pix_tag_p1) r_pix_rdata <= mem_rdata;
      if (r_cpu_tag_p1) r_cpu_rdata <= mem_rdata;
    end
  end

  always_comb begin
    w_wait_nxt = r_wait;
    if (w_cpu_gnt) begin
      w_wait_nxt = '0;
    end else if (cpu_valid && (r_wait != LIMIT_CNT)) begin
      w_wait_nxt = r_wait + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_25m or negedge rst_n) begin
    if (!rst_n) begin
      r_wait    <= '0;
      r_starved <= 1'b0;
    end else begin
      r_wait <= w_wait_nxt;
      if (clear_start) begin
        r_starved <= 1'b0;
      end else if (w_wait_nxt == LIMIT_CNT) begin
        r_starved <= 1'b1;
      end
    end
  end

  assign mem_en      = r_mem_en;
  assign mem_we      = r_mem_we;
  assign mem_addr    = r_mem_addr;
  assign mem_wdata   = r_mem_wdata;
  assign pix_rvalid  = r_pix_rvalid;
  assign pix_rdata   = r_pix_rdata;
  assign cpu_rvalid  = r_cpu_rvalid;
  assign cpu_rdata   = r_cpu_rdata;
  assign clear_busy  = w_clr_busy;
  assign cpu_starved = r_starved;

endmodule

// File: tb/tb_vram_arbiter.sv
// Scoreboard bench for vram_arbiter: a behavioural model predicts every cycle's
// RAM command and every read return; a monitor compares them against the DUT.
module tb_vram_arbiter;

  localparam int AW   = 16;
  localparam int DW   = 16;
  localparam int LAST = 7;
  localparam int LIM  = 4;
  localparam int MW   = 256;

  logic          clk_25m = 1'b0;
  logic          rst_n;
  logic          in_blank;
  logic          pix_req;
  logic [AW-1:0] pix_addr;
  logic          pix_rvalid;
  logic [DW-1:0] pix_rdata;
  logic          cpu_valid;
  logic          cpu_we;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata;
  logic          cpu_ready;
  logic          cpu_rvalid;
  logic [DW-1:0] cpu_rdata;
  logic          clear_start;
  logic [DW-1:0] clear_value;
  logic          clear_busy;
  logic          cpu_starved;
  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata = '0;

  always #20 clk_25m = ~clk_25m;

  vram_arbiter #(
    .ADDR_WIDTH   (AW),
    .DATA_WIDTH   (DW),
    .CLEAR_LAST   (LAST),
    .STARVE_LIMIT (LIM)
  ) dut (
    .clk_25m     (clk_25m),
    .rst_n       (rst_n),
    .in_blank    (in_blank),
    .pix_req     (pix_req),
    .pix_addr    (pix_addr),
    .pix_rvalid  (pix_rvalid),
    .pix_rdata   (pix_rdata),
    .cpu_valid   (cpu_valid),
    .cpu_we      (cpu_we),
    .cpu_addr    (cpu_addr),
    .cpu_wdata   (cpu_wdata),
    .cpu_ready   (cpu_ready),
    .cpu_rvalid  (cpu_rvalid),
    .cpu_rdata   (cpu_rdata),
    .clear_start (clear_start),
    .clear_value (clear_value),
    .clear_busy  (clear_busy),
    .cpu_starved (cpu_starved),
    .mem_en      (mem_en),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata)
  );

  function automatic logic [DW-1:0] init_val(input int a);
    if (a == 16) return 16'hBEEF;
    return DW'((a * 40503) ^ 23130);
  endfunction

  // Environment: synchronous single-port RAM with 1-cycle read latency.
  logic [DW-1:0] ram    [MW];
  bit            ram_wr [MW];
  always @(posedge clk_25m) begin
    if (mem_en) begin
      if (mem_we) begin
        ram[mem_addr[7:0]]    <= mem_wdata;
        ram_wr[mem_addr[7:0]] <= 1'b1;
      end else begin
        mem_rdata <= ram_wr[mem_addr[7:0]] ? ram[mem_addr[7:0]] : init_val(int'(mem_addr[7:0]));
      end
    end
  end

  int cyc = 0;
  always @(posedge clk_25m) cyc <= cyc + 1;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @cyc %0d: got %0h, required %0h", name, cyc, act, exp);
    end
  endtask

  typedef struct {
    int            cyc;
    logic          en;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic          busy;
    logic          starved;
  } cmd_t;

  typedef struct {
    int            cyc;
    logic [DW-1:0] data;
  } rd_t;

  cmd_t q_cmd[$];
  rd_t  q_pix[$];
  rd_t  q_cpu[$];
  bit   q_rdy[$];

  // Reference model state
  logic [DW-1:0] refmem [MW];
  bit            m_init    = 1'b0;
  bit            m_busy    = 1'b0;
  int            m_ptr     = 0;
  logic [DW-1:0] m_val     = '0;
  int            m_wait    = 0;
  bit            m_starved = 1'b0;
  bit            m_acc     = 1'b0;
  bit            m_elig;
  cmd_t          m_c;
  rd_t           m_r;

  initial forever begin
    @(negedge clk_25m);
    #1;
    if (!m_init) begin
      for (int i = 0; i < MW; i++) refmem[i] = init_val(i);
      m_init = 1'b1;
    end
    if (!rst_n) begin
      q_cmd.delete(); q_pix.delete(); q_cpu.delete(); q_rdy.delete();
      m_busy = 1'b0; m_ptr = 0; m_val = '0; m_wait = 0; m_starved = 1'b0; m_acc = 1'b0;
    end else begin
      m_elig = m_busy && in_blank;
      m_acc  = cpu_valid && !pix_req && !m_elig;
      q_rdy.push_back(m_acc);
      m_c = '{cyc: cyc + 1, en: 1'b0, we: 1'b0, addr: '0, wdata: '0, busy: 1'b0, starved: 1'b0};
      if (pix_req) begin
        m_c.en   = 1'b1;
        m_c.addr = pix_addr;
        m_r.cyc  = cyc + 3;
        m_r.data = refmem[pix_addr[7:0]];
        q_pix.push_back(m_r);
      end else if (m_elig) begin
        m_c.en    = 1'b1;
        m_c.we    = 1'b1;
        m_c.addr  = AW'(m_ptr);
        m_c.wdata = m_val;
        refmem[m_ptr] = m_val;
        if (m_ptr == LAST) begin
          m_busy = 1'b0;
          m_ptr  = 0;
        end else begin
          m_ptr++;
        end
      end else if (m_acc) begin
        m_c.en   = 1'b1;
        m_c.we   = cpu_we;
        m_c.addr = cpu_addr;
        if (cpu_we) begin
          m_c.wdata = cpu_wdata;
          refmem[cpu_addr[7:0]] = cpu_wdata;
        end else begin
          m_r.cyc  = cyc + 3;
          m_r.data = refmem[cpu_addr[7:0]];
          q_cpu.push_back(m_r);
        end
      end
      if (m_acc) m_wait = 0;
      else if (cpu_valid) m_wait = (m_wait < LIM) ? m_wait + 1 : LIM;
      if (clear_start) begin
        m_busy = 1'b1; m_ptr = 0; m_val = clear_value; m_starved = 1'b0;
      end else if (m_wait == LIM) begin
        m_starved = 1'b1;
      end
      m_c.busy    = m_busy;
      m_c.starved = m_starved;
      q_cmd.push_back(m_c);
    end
  end

  cmd_t mon_c;
  rd_t  mon_r;

  initial forever begin
    @(negedge clk_25m);
    #2;
    if (!rst_n) begin
      chk("reset_ctrl", 64'({pix_rvalid, cpu_ready, cpu_rvalid, clear_busy, cpu_starved, mem_en, mem_we}), 64'(0));
      chk("reset_data", 64'({pix_rdata, cpu_rdata, mem_addr, mem_wdata}), 64'(0));
    end else begin
      if (q_rdy.size() != 0) chk("cpu_ready", 64'(cpu_ready), 64'(q_rdy.pop_front()));
      if (q_cmd.size() != 0 && q_cmd[0].cyc == cyc) begin
        mon_c = q_cmd.pop_front();
        chk("mem_en", 64'(mem_en), 64'(mon_c.en));
        if (mon_c.en) begin
          chk("mem_we", 64'(mem_we), 64'(mon_c.we));
          chk("mem_addr", 64'(mem_addr), 64'(mon_c.addr));
          if (mon_c.we) chk("mem_wdata", 64'(mem_wdata), 64'(mon_c.wdata));
        end
        chk("clear_busy", 64'(clear_busy), 64'(mon_c.busy));
        chk("cpu_starved", 64'(cpu_starved), 64'(mon_c.starved));
      end else begin
        chk("mem_en_idle", 64'(mem_en), 64'(0));
      end
      if (pix_rvalid) begin
        if (q_pix.size() == 0) chk("pix_rvalid_unexpected", 64'(pix_rvalid), 64'(0));
        else begin
          mon_r = q_pix.pop_front();
          chk("pix_rvalid_cycle", 64'(cyc), 64'(mon_r.cyc));
          chk("pix_rdata", 64'(pix_rdata), 64'(mon_r.data));
        end
      end else if (q_pix.size() != 0 && q_pix[0].cyc <= cyc) begin
        chk("pix_rvalid_missing", 64'(pix_rvalid), 64'(1));
        void'(q_pix.pop_front());
      end
      if (cpu_rvalid) begin
        if (q_cpu.size() == 0) chk("cpu_rvalid_unexpected", 64'(cpu_rvalid), 64'(0));
        else begin
          mon_r = q_cpu.pop_front();
          chk("cpu_rvalid_cycle", 64'(cyc), 64'(mon_r.cyc));
          chk("cpu_rdata", 64'(cpu_rdata), 64'(mon_r.data));
        end
      end else if (q_cpu.size() != 0 && q_cpu[0].cyc <= cyc) begin
        chk("cpu_rvalid_missing", 64'(cpu_rvalid), 64'(1));
        void'(q_cpu.pop_front());
      end
    end
  end

  task automatic bg(input int pix_pct);
    pix_req     = ($urandom_range(99) < pix_pct);
    pix_addr    = AW'($urandom_range(MW - 1));
    if ($urandom_range(7) == 0) in_blank = ~in_blank;
    clear_start = ($urandom_range(99) < 2);
    clear_value = DW'($urandom);
  endtask

  // Holds the request stable until the model says it was taken; pix_pct < 0 leaves other inputs alone.
  task automatic cpu_op(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d, input int pix_pct);
    int n;
    n = 0;
    cpu_valid = 1'b1; cpu_we = we; cpu_addr = a; cpu_wdata = d;
    do begin
      @(negedge clk_25m);
      n++;
      if (!m_acc && pix_pct >= 0) bg(pix_pct);
    end while (!m_acc && n < 300);
    cpu_valid   = 1'b0;
    clear_start = 1'b0;
    if (!m_acc) begin
      n_vec++; n_err++;
      $display("FAIL cpu_accept_timeout: waited %0d cycles, required acceptance", n);
    end
  endtask

  task automatic wait_clear_done(input int budget);
    int n;
    n = 0;
    while (m_busy && n < budget) begin
      @(negedge clk_25m);
      n++;
      if (n % 4 == 0) in_blank = ~in_blank;
    end
    if (m_busy) begin
      n_vec++; n_err++;
      $display("FAIL clear_done_timeout: still busy after %0d cycles, required idle", n);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required self-termination");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; in_blank = 1'b0; pix_req = 1'b0; pix_addr = '0;
    cpu_valid = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    clear_start = 1'b0; clear_value = '0;
    repeat (3) @(negedge clk_25m);
    rst_n = 1'b1;
    @(negedge clk_25m);

    // Pixel read of 0x0010 (holds 0xBEEF)
    pix_req = 1'b1; pix_addr = 16'h0010;
    @(negedge clk_25m);
    pix_req = 1'b0;
    repeat (3) @(negedge clk_25m);

    // Contention: pixel wins for 3 cycles, then a single CPU write
    pix_req = 1'b1; pix_addr = 16'h0030;
    cpu_valid = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h0020; cpu_wdata = 16'h1234;
    repeat (3) @(negedge clk_25m);
    pix_req = 1'b0;
    @(negedge clk_25m);
    cpu_valid = 1'b0;
    repeat (2) @(negedge clk_25m);

    // CPU read-after-write
    cpu_op(1'b1, 16'h0005, 16'h00AA, -1);
    cpu_op(1'b0, 16'h0005, 16'h0000, -1);
    cpu_op(1'b0, 16'h0020, 16'h0000, -1);
    repeat (3) @(negedge clk_25m);

    // Randomised traffic with clears, blanking and pixel contention
    for (int t = 0; t < 150; t++) begin
      cpu_op(1'($urandom_range(1)), AW'($urandom_range(31)), DW'($urandom), 30);
      repeat ($urandom_range(2)) begin
        @(negedge clk_25m);
        bg(30);
      end
      clear_start = 1'b0;
    end
    pix_req = 1'b0; clear_start = 1'b0; in_blank = 1'b1;
    wait_clear_done(100);
    repeat (3) @(negedge clk_25m);

    // Starvation: pixel blocks the CPU for 6 cycles
    in_blank = 1'b0;
    pix_req = 1'b1; pix_addr = 16'h0040;
    cpu_valid = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h0021; cpu_wdata = 16'h5555;
    repeat (6) @(negedge clk_25m);
    pix_req = 1'b0;
    @(negedge clk_25m);
    cpu_valid = 1'b0;
    repeat (2) @(negedge clk_25m);
    clear_start = 1'b1; clear_value = 16'h0000;
    @(negedge clk_25m);
    clear_start = 1'b0;
    repeat (2) @(negedge clk_25m);

    // Clear restart with 0x0F0F while blanking toggles every 4 cycles
    in_blank = 1'b1;
    clear_start = 1'b1; clear_value = 16'h0F0F;
    @(negedge clk_25m);
    clear_start = 1'b0;
    wait_clear_done(200);
    in_blank = 1'b0;
    for (int a = 0; a <= LAST; a++) cpu_op(1'b0, AW'(a), 16'h0000, -1);
    repeat (3) @(negedge clk_25m);

    // Reset one cycle after a CPU read grant: the return must never appear
    cpu_valid = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0005;
    @(negedge clk_25m);
    cpu_valid = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk_25m);
    rst_n = 1'b1;
    repeat (6) @(negedge clk_25m);
    cpu_op(1'b0, 16'h0020, 16'h0000, -1);
    repeat (6) @(negedge clk_25m);

    chk("pix_returns_outstanding", 64'(q_pix.size()), 64'(0));
    chk("cpu_returns_outstanding", 64'(q_cpu.size()), 64'(0));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
